// File: rtl/dmac_sync_fifo.sv
// dmac_sync_fifo: parametrised first-word-fall-through synchronous FIFO with occupancy count,
// almost-full/empty flags and sticky errors. Define DMAC_FIFO_OUTREG_EN for a registered output stage.
module dmac_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LG2  = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_LG2:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int PW    = DEPTH_LG2 + 1;
`ifdef DMAC_FIFO_OUTREG_EN
  localparam int CAP   = DEPTH + 1;
`else
  localparam int CAP   = DEPTH;
`endif
  localparam logic [PW-1:0] CAP_C = PW'(CAP);
  localparam logic [PW-1:0] AF_C  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C  = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0] wrptr_r, rdptr_r, count_r;
  logic [PW-1:0] wrptr_nx_s, rdptr_nx_s, count_nx_s;
  logic          full_r, af_r, empty_r, ae_r, overflow_r, underflow_r;
  logic          full_nx_s, af_nx_s, empty_nx_s, ae_nx_s, ovf_nx_s, unf_nx_s;
  logic          wr_ok_s, rd_ok_s;
`ifdef DMAC_FIFO_OUTREG_EN
  logic [DATA_WIDTH-1:0] od_r;
  logic                  ov_r, ov_nx_s, load_s;
  logic [PW-1:0]         mem_cnt_s;
`endif

  // Next-state pointers, occupancy and flags; flush overrides every request.
  always_comb begin
    wr_ok_s = wren_i & ~full_r;
    rd_ok_s = rden_i & ~empty_r;
`ifdef DMAC_FIFO_OUTREG_EN
    // The prefetch stage pulls from storage whenever it is free or being popped.
    mem_cnt_s  = wrptr_r - rdptr_r;
    load_s     = (mem_cnt_s != {PW{1'b0}}) & (~ov_r | rd_ok_s);
    rdptr_nx_s = rdptr_r + {{(PW-1){1'b0}}, load_s};
    ov_nx_s    = load_s | (ov_r & ~rd_ok_s);
`else
    rdptr_nx_s = rdptr_r + {{(PW-1){1'b0}}, rd_ok_s};
`endif
    wrptr_nx_s = wrptr_r + {{(PW-1){1'b0}}, wr_ok_s};
    ovf_nx_s   = overflow_r | (wren_i & full_r);
    unf_nx_s   = underflow_r | (rden_i & empty_r);
    if (flush_i) begin
      wrptr_nx_s = {PW{1'b0}};
      rdptr_nx_s = {PW{1'b0}};
      ovf_nx_s   = 1'b0;
      unf_nx_s   = 1'b0;
`ifdef DMAC_FIFO_OUTREG_EN
      ov_nx_s    = 1'b0;
`endif
    end else begin
      wrptr_nx_s = wrptr_nx_s;
      rdptr_nx_s = rdptr_nx_s;
    end
`ifdef DMAC_FIFO_OUTREG_EN
    count_nx_s = (wrptr_nx_s - rdptr_nx_s) + {{(PW-1){1'b0}}, ov_nx_s};
    empty_nx_s = ~ov_nx_s;
`else
    count_nx_s = wrptr_nx_s - rdptr_nx_s;
    empty_nx_s = (count_nx_s == {PW{1'b0}});
`endif
    full_nx_s  = (count_nx_s == CAP_C);
    af_nx_s    = (count_nx_s >= AF_C);
    ae_nx_s    = (count_nx_s <= AE_C);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_r     <= {PW{1'b0}};
      rdptr_r     <= {PW{1'b0}};
      count_r     <= {PW{1'b0}};
      full_r      <= 1'b0;
      af_r        <= 1'b0;
      empty_r     <= 1'b1;
      ae_r        <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wrptr_r     <= wrptr_nx_s;
      rdptr_r     <= rdptr_nx_s;
      count_r     <= count_nx_s;
      full_r      <= full_nx_s;
      af_r        <= af_nx_s;
      empty_r     <= empty_nx_s;
      ae_r        <= ae_nx_s;
      overflow_r  <= ovf_nx_s;
      underflow_r <= unf_nx_s;
    end
  end

  // Storage array; deliberately not reset, and rejected or flushed writes never land.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !flush_i) begin
      mem_r[wrptr_r[DEPTH_LG2-1:0]] <= wdata_i;
    end
  end

`ifdef DMAC_FIFO_OUTREG_EN
  // Output prefetch stage: holds the head entry so rdata_o comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_r <= 1'b0;
      od_r <= {DATA_WIDTH{1'b0}};
    end else if (flush_i) begin
      ov_r <= 1'b0;
      od_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ov_r <= ov_nx_s;
      if (load_s) begin
        od_r <= mem_r[rdptr_r[DEPTH_LG2-1:0]];
      end
    end
  end

  assign rdata_o = od_r;
`else
  assign rdata_o = mem_r[rdptr_r[DEPTH_LG2-1:0]];
`endif

  assign full_o         = full_r;
  assign almost_full_o  = af_r;
  assign empty_o        = empty_r;
  assign almost_empty_o = ae_r;
  assign count_o        = count_r;
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

endmodule

// File: tb/tb_dmac_sync_fifo.sv
// tb_dmac_sync_fifo: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the FIFO rules (default build).
module tb_dmac_sync_fifo;

  localparam int DW    = 32;
  localparam int LG2   = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, wren_i, rden_i;
  logic [DW-1:0] wdata_i;
  logic          full_o, almost_full_o, empty_o, almost_empty_o;
  logic          overflow_o, underflow_o;
  logic [DW-1:0] rdata_o;
  logic [LG2:0]  count_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;

  typedef struct {
    bit            flush, wr, rd;
    logic [DW-1:0] wdata;
    int            cnt;
    bit            empty, full, ae, ovf, unf;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[8];

  dmac_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_LG2(LG2), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wren_i(wren_i), .wdata_i(wdata_i),
    .full_o(full_o), .almost_full_o(almost_full_o), .rden_i(rden_i), .rdata_o(rdata_o),
    .empty_o(empty_o), .almost_empty_o(almost_empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies the FIFO rules to the queue for one edge, using pre-edge state.
  task automatic model_step(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
    bit full, empty;
    if (f) begin
      model_reset();
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (w && full) m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      if (r && !empty) void'(q.pop_front());
      if (w && !full) q.push_back(d);
    end
  endtask

  task automatic cycle(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
    flush_i = f; wren_i = w; rden_i = r; wdata_i = d;
    model_step(f, w, r, d);
    @(posedge clk);
    #1;
    flush_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count_o), n);
    chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, ".full"},  32'(full_o),  32'(n == DEPTH));
    chk({tag, ".af"},    32'(almost_full_o),  32'(n >= AF));
    chk({tag, ".ae"},    32'(almost_empty_o), 32'(n <= AE));
    chk({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
    if (n != 0) chk({tag, ".rdata"}, rdata_o, q[0]);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0; wdata_i = '0;
    model_reset();
    tbl[0] = '{0, 1, 0, 32'h11, 1, 0, 0, 1, 0, 0, 32'h11};
    tbl[1] = '{0, 1, 0, 32'h22, 2, 0, 0, 1, 0, 0, 32'h11};
    tbl[2] = '{0, 1, 1, 32'h33, 2, 0, 0, 1, 0, 0, 32'h22};
    tbl[3] = '{0, 0, 1, 32'h00, 1, 0, 0, 1, 0, 0, 32'h33};
    tbl[4] = '{0, 0, 1, 32'h00, 0, 1, 0, 1, 0, 0, 32'h00};
    tbl[5] = '{0, 0, 1, 32'h00, 0, 1, 0, 1, 0, 1, 32'h00};
    tbl[6] = '{0, 1, 1, 32'h44, 1, 0, 0, 1, 0, 1, 32'h44};
    tbl[7] = '{1, 1, 1, 32'h99, 0, 1, 0, 1, 0, 0, 32'h00};

    @(posedge clk); @(posedge clk); #1;
    chk("rst.count", 32'(count_o), 0);
    chk("rst.empty", 32'(empty_o), 1);
    chk("rst.full",  32'(full_o), 0);
    chk("rst.ae",    32'(almost_empty_o), 1);
    chk("rst.af",    32'(almost_full_o), 0);
    chk("rst.ovf",   32'(overflow_o), 0);
    chk("rst.unf",   32'(underflow_o), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].wdata);
      chk($sformatf("vec%0d.count", i), 32'(count_o), tbl[i].cnt);
      chk($sformatf("vec%0d.empty", i), 32'(empty_o), 32'(tbl[i].empty));
      chk($sformatf("vec%0d.full", i),  32'(full_o), 32'(tbl[i].full));
      chk($sformatf("vec%0d.ae", i),    32'(almost_empty_o), 32'(tbl[i].ae));
      chk($sformatf("vec%0d.ovf", i),   32'(overflow_o), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d.unf", i),   32'(underflow_o), 32'(tbl[i].unf));
      if (!tbl[i].empty) chk($sformatf("vec%0d.rdata", i), rdata_o, tbl[i].rdata);
    end

    // Offset the pointers so the 16-word fill wraps storage.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 32'hA0 + i);
      cycle(0, 0, 1, 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, i);
      check_model($sformatf("fill%0d", i));
      if (i == 10) chk("fill.af_before12", 32'(almost_full_o), 0);
      if (i == 11) chk("fill.af_at12", 32'(almost_full_o), 1);
      if (i == 1)  chk("fill.ae_at2", 32'(almost_empty_o), 1);
      if (i == 2)  chk("fill.ae_at3", 32'(almost_empty_o), 0);
    end
    chk("fill.full", 32'(full_o), 1);
    chk("fill.count", 32'(count_o), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.data", i), rdata_o, i);
      cycle(0, 0, 1, 32'h0);
    end
    chk("drain.empty", 32'(empty_o), 1);

    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 32'd100 + i);
    cycle(0, 1, 1, 32'hBAD);
    chk("fullwr.count", 32'(count_o), 15);
    chk("fullwr.ovf", 32'(overflow_o), 1);
    chk("fullwr.head", rdata_o, 32'd101);
    check_model("fullwr");
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("drain2_%0d.data", i), rdata_o, 32'd101 + i);
      cycle(0, 0, 1, 32'h0);
    end
    cycle(0, 1, 1, 32'h77);
    chk("emptywr.count", 32'(count_o), 1);
    chk("emptywr.unf", 32'(underflow_o), 1);
    chk("emptywr.data", rdata_o, 32'h77);

    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 32'd200 + i);
    cycle(1, 1, 0, 32'hDEAD);
    chk("flush.count", 32'(count_o), 0);
    chk("flush.empty", 32'(empty_o), 1);
    chk("flush.ovf", 32'(overflow_o), 0);
    chk("flush.unf", 32'(underflow_o), 0);
    cycle(0, 1, 0, 32'h55);
    chk("postflush.data", rdata_o, 32'h55);
    cycle(0, 0, 1, 32'h0);
    chk("postflush.empty", 32'(empty_o), 1);

    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 32'd300 + i);
    chk("prerst.count", 32'(count_o), 9);
    #2 rst = 1'b1;
    #1;
    chk("asyncrst.count", 32'(count_o), 0);
    chk("asyncrst.empty", 32'(empty_o), 1);
    chk("asyncrst.ae", 32'(almost_empty_o), 1);
    chk("asyncrst.full", 32'(full_o), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_model("afterrst");

    // Random traffic with a write bias that drifts between fill and drain phases.
    for (int c = 0; c < 1600; c++) begin
      int wb;
      wb = ((c / 200) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < wb,
            $urandom_range(0, 99) < 50, $urandom);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmac_sync_fifo.md
Name: dmac_sync_fifo

Overview:
Parametrised synchronous FIFO, the next generation of the DMAC FIFO. It sits between the DMAC AXI read engine and write engine, and in other DMAC channel datapaths.
- First-word-fall-through read port.
- Occupancy count output.
- Programmable almost-full and almost-empty flags for burst-level flow control.
- Synchronous flush.
- Sticky overflow and underflow error flags.

Parameters:
DATA_WIDTH, 32, width of each entry in bits (>=1)
DEPTH_LG2, 4, log2 of the storage depth; DEPTH = 2**DEPTH_LG2 entries (>=1)
AF_LEVEL, 12, almost_full_o asserts when occupancy >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty_o asserts when occupancy <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous clear of pointers, count and error flags
wren_i  input  1  write request
wdata_i  input  DATA_WIDTH  write data
full_o  output  1  no free entry
almost_full_o  output  1  occupancy >= AF_LEVEL
rden_i  input  1  read request (pops the head entry)
rdata_o  output  DATA_WIDTH  head entry; valid only while empty_o=0
empty_o  output  1  no valid entry
almost_empty_o  output  1  occupancy <= AE_LEVEL
count_o  output  DEPTH_LG2+1  current occupancy, 0..DEPTH
overflow_o  output  1  sticky: write attempted while full
underflow_o  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1, asynchronous assert): wrptr, rdptr and count are 0; empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.
- Reset does not clear storage. rdata_o is don't-care while empty_o=1.
- Pointers are DEPTH_LG2+1 bits wide. The MSB is the wrap bit; the low bits index storage. Pointers wrap modulo 2*DEPTH.
- Write accept: wr_ok = wren_i & ~full_o. Data is stored at wrptr and wrptr increments.
- Read accept: rd_ok = rden_i & ~empty_o. rdptr increments.
- All flags and count_o are registers, computed from next-state pointers (no combinational path from wren_i/rden_i to any output).
- count_o = wrptr - rdptr, modulo 2**(DEPTH_LG2+1).
- Write-to-read latency is 1 cycle. A write accepted at edge N to an empty FIFO gives empty_o=0 and rdata_o=wdata after edge N.
- rdata_o = mem[rdptr] and changes only after an accepted read or an accepted write into an empty FIFO.
- Simultaneous wr_ok and rd_ok: count is unchanged and all flags hold.
- Full FIFO with wren_i=rden_i=1: the read is accepted, the write is rejected, overflow_o is set, and the FIFO ends at DEPTH-1.
- Empty FIFO with wren_i=rden_i=1: the write is accepted, the read is rejected, underflow_o is set, and the FIFO ends at 1.
- overflow_o and underflow_o stay set until rst or flush_i.
- flush_i=1: on the next edge, pointers, count and error flags return to their reset values. Any write or read in that cycle is discarded. flush_i has priority over wren_i and rden_i.
- A rejected write never modifies storage.

Optional Feature:
DMAC_FIFO_OUTREG_EN
- Defined: a one-entry output register (prefetch stage) is added after the storage array. rdata_o and empty_o come from this register, so there is no RAM-to-output combinational path (retiming-friendly).
  - Total capacity becomes DEPTH+1, and count_o includes the output stage.
  - A write to an empty FIFO reaches rdata_o and clears empty_o after 2 edges.
  - Back-to-back reads sustain 1 entry per cycle.
  - flush_i and rst also clear the output stage.
- Undefined: behaviour exactly as above, with capacity DEPTH and 1-cycle latency.

Test Plan:
All scenarios use defaults DATA_WIDTH=32, DEPTH_LG2=4, AF_LEVEL=12, AE_LEVEL=2.
1. Reset, then write 0x11 in one cycle -> next cycle: empty_o=0, rdata_o=0x11, count_o=1, almost_empty_o=1.
2. Write 16 words 0..15 with no reads -> full_o=1, count_o=16; almost_full_o rises after the 12th write; almost_empty_o falls after the 3rd write.
3. Drain all 16 in order, with pointers wrapped once -> values 0..15 in order; empty_o=1 after the last pop.
4. Full FIFO, wren_i=rden_i=1 for one cycle -> pops 0, count_o=15, overflow_o=1. Empty FIFO with both asserted -> count_o=1, underflow_o=1.
5. Fill to 7 entries, assert flush_i together with wren_i -> count_o=0, empty_o=1, error flags 0. The write is not stored.
6. Assert rst mid-stream at count_o=9, off the clock edge -> outputs take reset values immediately, without waiting for a clock edge.
